// File: rtl/ray_aabb_hit_collector.sv
// rtl/ray_aabb_hit_collector.sv - pairs delayed ray/box tags with hit_miss and queues per-ray hit records
module ray_aabb_hit_collector #(
  parameter int LATENCY    = 42,
  parameter int ID_W       = 16,
  parameter int BOX_W      = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ID_W-1:0]   issue_ray_id,
  input  logic [BOX_W-1:0]  issue_box_id,
  input  logic              issue_last,
  input  logic              hit_miss,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ID_W-1:0]   res_ray_id,
  output logic              res_hit,
  output logic [BOX_W-1:0]  res_first_box,
  output logic [BOX_W:0]    res_hit_count,
  output logic              overflow,
  output logic              seq_err,
  output logic              busy
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW    = AW + 1;
  localparam int CW    = BOX_W + 1;
  localparam int REC_W = ID_W + 1 + BOX_W + CW;

  typedef enum logic {S_IDLE, S_OPEN} state_t;

  // Tag delay line matched to the core latency
  logic [LATENCY-1:0] dl_vld_q;
  logic [ID_W-1:0]    dl_ray_q  [LATENCY];
  logic [BOX_W-1:0]   dl_box_q  [LATENCY];
  logic               dl_last_q [LATENCY];

  // Valid bits are the only reset part of the delay line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_vld_q <= '0;
    end else begin
      dl_vld_q[0] <= issue_valid;
      for (int i = 1; i < LATENCY; i++) dl_vld_q[i] <= dl_vld_q[i-1];
    end
  end

  // Payload shift, no reset needed since valid gates its use
  always_ff @(posedge clk) begin
    dl_ray_q[0]  <= issue_ray_id;
    dl_box_q[0]  <= issue_box_id;
    dl_last_q[0] <= issue_last;
    for (int i = 1; i < LATENCY; i++) begin
      dl_ray_q[i]  <= dl_ray_q[i-1];
      dl_box_q[i]  <= dl_box_q[i-1];
      dl_last_q[i] <= dl_last_q[i-1];
    end
  end

  logic              t_vld;
  logic [ID_W-1:0]   t_ray;
  logic [BOX_W-1:0]  t_box;
  logic              t_last;

  assign t_vld  = dl_vld_q[LATENCY-1];
  assign t_ray  = dl_ray_q[LATENCY-1];
  assign t_box  = dl_box_q[LATENCY-1];
  assign t_last = dl_last_q[LATENCY-1];

  // Accumulator state
  state_t            state_q, state_d;
  logic [ID_W-1:0]   acc_ray_q, acc_ray_d;
  logic              acc_hit_q, acc_hit_d;
  logic [BOX_W-1:0]  acc_first_q, acc_first_d;
  logic [CW-1:0]     acc_cnt_q, acc_cnt_d;
  logic              seq_err_q, seq_err_d;
  logic              overflow_q, overflow_d;

  // Two records may be produced per cycle: a group closed by an id change (a)
  // and the record finished by the current tag (b), written in that order.
  logic              push_a, push_b;
  logic [REC_W-1:0]  rec_a, rec_b;
  logic              start_new;
  logic              n_hit;
  logic [BOX_W-1:0]  n_first;
  logic [CW-1:0]     n_cnt;

  // Accumulator next state and record generation
  always_comb begin
    state_d     = state_q;
    acc_ray_d   = acc_ray_q;
    acc_hit_d   = acc_hit_q;
    acc_first_d = acc_first_q;
    acc_cnt_d   = acc_cnt_q;
    seq_err_d   = seq_err_q;
    push_a      = 1'b0;
    push_b      = 1'b0;
    rec_a       = {acc_ray_q, acc_hit_q, acc_first_q, acc_cnt_q};
    rec_b       = '0;
    start_new   = 1'b0;
    n_hit       = 1'b0;
    n_first     = '1;
    n_cnt       = '0;
    if (t_vld) begin
      start_new = (state_q == S_IDLE);
      if (state_q == S_OPEN && t_ray != acc_ray_q) begin
        seq_err_d = 1'b1;
        push_a    = 1'b1;
        start_new = 1'b1;
      end
      if (start_new) begin
        n_hit   = hit_miss;
        n_first = hit_miss ? t_box : '1;
        n_cnt   = hit_miss ? CW'(1) : '0;
      end else begin
        n_hit   = acc_hit_q | hit_miss;
        n_first = (hit_miss && !acc_hit_q) ? t_box : acc_first_q;
        n_cnt   = (hit_miss && acc_cnt_q != '1) ? acc_cnt_q + CW'(1) : acc_cnt_q;
      end
      if (t_last) begin
        push_b  = 1'b1;
        rec_b   = {t_ray, n_hit, n_first, n_cnt};
        state_d = S_IDLE;
      end else begin
        state_d     = S_OPEN;
        acc_ray_d   = t_ray;
        acc_hit_d   = n_hit;
        acc_first_d = n_first;
        acc_cnt_d   = n_cnt;
      end
    end
  end

  // Accumulator and sticky sequence error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_ray_q   <= '0;
      acc_hit_q   <= 1'b0;
      acc_first_q <= '1;
      acc_cnt_q   <= '0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_ray_q   <= acc_ray_d;
      acc_hit_q   <= acc_hit_d;
      acc_first_q <= acc_first_d;
      acc_cnt_q   <= acc_cnt_d;
      seq_err_q   <= seq_err_d;
    end
  end

  // Result FIFO
  logic [REC_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    cnt_w, free_w;
  logic             pop, acc_a, acc_b;
  logic [AW-1:0]    idx_a, idx_b;
  logic [REC_W-1:0] head;

  // Space check, drop detection and pointer updates
  always_comb begin
    cnt_w      = wr_ptr_q - rd_ptr_q;
    pop        = (cnt_w != '0) && res_ready;
    free_w     = PW'(FIFO_DEPTH) - cnt_w + PW'(pop);
    acc_a      = push_a && (free_w != '0);
    acc_b      = push_b && (free_w >= (push_a ? PW'(2) : PW'(1)));
    overflow_d = overflow_q | (push_a && !acc_a) | (push_b && !acc_b);
    idx_a      = wr_ptr_q[AW-1:0];
    idx_b      = wr_ptr_q[AW-1:0] + AW'(acc_a);
    wr_ptr_d   = wr_ptr_q + PW'(acc_a) + PW'(acc_b);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
  end

  // FIFO storage and pointers; storage reset so outputs read 0 when empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (acc_a) mem_q[idx_a] <= rec_a;
      if (acc_b) mem_q[idx_b] <= rec_b;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign res_valid     = (wr_ptr_q != rd_ptr_q);
  assign res_ray_id    = head[REC_W-1 -: ID_W];
  assign res_hit       = head[BOX_W + CW];
  assign res_first_box = head[CW +: BOX_W];
  assign res_hit_count = head[CW-1:0];
  assign overflow      = overflow_q;
  assign seq_err       = seq_err_q;
  assign busy          = (|dl_vld_q) || (state_q == S_OPEN);

endmodule

// File: tb/tb_ray_aabb_hit_collector.sv
// tb/tb_ray_aabb_hit_collector.sv - directed table and sequence checks for ray_aabb_hit_collector
module tb_ray_aabb_hit_collector;
  localparam int LATENCY = 42;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [15:0] issue_ray_id;
  logic [7:0]  issue_box_id;
  logic        issue_last;
  logic        hit_miss;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_ray_id;
  logic        res_hit;
  logic [7:0]  res_first_box;
  logic [8:0]  res_hit_count;
  logic        overflow;
  logic        seq_err;
  logic        busy;
  logic        hit_plan;
  logic [LATENCY-1:0] core_q = '0;

  int n_checks = 0;
  int n_fail   = 0;

  ray_aabb_hit_collector dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ray_id(issue_ray_id),
    .issue_box_id(issue_box_id), .issue_last(issue_last),
    .hit_miss(hit_miss),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_ray_id(res_ray_id), .res_hit(res_hit),
    .res_first_box(res_first_box), .res_hit_count(res_hit_count),
    .overflow(overflow), .seq_err(seq_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the core: the planned hit appears LATENCY edges after issue
  always_ff @(posedge clk) core_q <= {core_q[LATENCY-2:0], issue_valid & hit_plan};
  assign hit_miss = core_q[LATENCY-1];

  typedef struct {
    logic [15:0] ray;
    int          n;
    logic [7:0]  mask;
    logic        exp_hit;
    logic [7:0]  exp_first;
    logic [8:0]  exp_cnt;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue_ray(input logic [15:0] ray, input int n, input logic [7:0] mask);
    for (int k = 0; k < n; k++) begin
      issue_valid  = 1'b1;
      issue_ray_id = ray;
      issue_box_id = 8'(k);
      issue_last   = (k == n - 1);
      hit_plan     = mask[k];
      @(negedge clk);
    end
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    hit_plan    = 1'b0;
  endtask

  task automatic issue_tag(input logic [15:0] ray, input logic last, input logic hit);
    issue_valid  = 1'b1;
    issue_ray_id = ray;
    issue_box_id = 8'd0;
    issue_last   = last;
    hit_plan     = hit;
    @(negedge clk);
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    hit_plan    = 1'b0;
  endtask

  task automatic pop_one();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    logic saw_valid;
    vecs[0] = '{16'd5,      4, 8'b0000_1010, 1'b1, 8'd1,   9'd2};
    vecs[1] = '{16'd9,      3, 8'b0000_0000, 1'b0, 8'hFF,  9'd0};
    vecs[2] = '{16'h1234,   1, 8'b0000_0001, 1'b1, 8'd0,   9'd1};
    vecs[3] = '{16'hABCD,   5, 8'b0001_0000, 1'b1, 8'd4,   9'd1};
    vecs[4] = '{16'd7,      8, 8'b1111_1111, 1'b1, 8'd0,   9'd8};

    rst = 1'b1; issue_valid = 1'b0; issue_ray_id = '0; issue_box_id = '0;
    issue_last = 1'b0; hit_plan = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset res_valid", res_valid, 0);
    chk("reset overflow", overflow, 0);
    chk("reset seq_err", seq_err, 0);
    chk("reset busy", busy, 0);
    chk("reset res_ray_id", res_ray_id, 0);
    chk("reset res_hit_count", res_hit_count, 0);

    // Table: each ray checked for exact latency, busy fall and record fields
    for (int v = 0; v < 5; v++) begin
      issue_ray(vecs[v].ray, vecs[v].n, vecs[v].mask);
      repeat (LATENCY - 1) @(negedge clk);
      chk($sformatf("v%0d early res_valid", v), res_valid, 0);
      chk($sformatf("v%0d early busy", v), busy, 1);
      @(negedge clk);
      chk($sformatf("v%0d res_valid", v), res_valid, 1);
      chk($sformatf("v%0d busy", v), busy, 0);
      chk($sformatf("v%0d ray", v), res_ray_id, vecs[v].ray);
      chk($sformatf("v%0d hit", v), res_hit, vecs[v].exp_hit);
      chk($sformatf("v%0d first", v), res_first_box, vecs[v].exp_first);
      chk($sformatf("v%0d count", v), res_hit_count, vecs[v].exp_cnt);
      pop_one();
      chk($sformatf("v%0d drained", v), res_valid, 0);
    end

    // Ray id change inside an open group
    chk("seq_err before", seq_err, 0);
    issue_tag(16'd3, 1'b0, 1'b1);
    issue_tag(16'd4, 1'b1, 1'b0);
    repeat (LATENCY) @(negedge clk);
    chk("seq_err set", seq_err, 1);
    chk("seq rec0 valid", res_valid, 1);
    chk("seq rec0 ray", res_ray_id, 3);
    chk("seq rec0 hit", res_hit, 1);
    chk("seq rec0 first", res_first_box, 0);
    chk("seq rec0 count", res_hit_count, 1);
    pop_one();
    chk("seq rec1 valid", res_valid, 1);
    chk("seq rec1 ray", res_ray_id, 4);
    chk("seq rec1 hit", res_hit, 0);
    chk("seq rec1 first", res_first_box, 8'hFF);
    chk("seq rec1 count", res_hit_count, 0);
    pop_one();
    chk("seq drained", res_valid, 0);

    // Full FIFO with a pop on the same edge as a push
    for (int i = 0; i < 9; i++) issue_tag(16'(32 + i), 1'b1, 1'b0);
    repeat (LATENCY - 1) @(negedge clk);
    chk("full head", res_ray_id, 32);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("pushpop overflow", overflow, 0);
    res_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      chk($sformatf("pushpop drain %0d", i), res_ray_id, 32 + i);
      @(negedge clk);
    end
    res_ready = 1'b0;
    chk("pushpop empty", res_valid, 0);

    // Overflow: ids 0..8 with no consumer, id 8 dropped
    for (int i = 0; i < 9; i++) issue_tag(16'(i), 1'b1, 1'b1);
    repeat (LATENCY - 1) @(negedge clk);
    chk("overflow before drop", overflow, 0);
    @(negedge clk);
    chk("overflow set", overflow, 1);
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf drain valid %0d", i), res_valid, 1);
      chk($sformatf("ovf drain id %0d", i), res_ray_id, i);
      @(negedge clk);
    end
    res_ready = 1'b0;
    chk("ovf id8 lost", res_valid, 0);
    chk("overflow sticky", overflow, 1);

    // Reset in the middle of a 4-box ray
    issue_ray(16'h55, 4, 8'b0000_1111);
    repeat (16) @(negedge clk);
    chk("midrst busy before", busy, 1);
    #2 rst = 1'b1;
    #1 chk("midrst busy async", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (res_valid) saw_valid = 1'b1;
    end
    chk("midrst no record", saw_valid, 0);
    chk("midrst overflow", overflow, 0);
    chk("midrst seq_err", seq_err, 0);
    chk("midrst busy", busy, 0);
    chk("midrst res_ray_id", res_ray_id, 0);
    chk("midrst res_hit", res_hit, 0);
    chk("midrst res_first_box", res_first_box, 0);
    chk("midrst res_hit_count", res_hit_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ray_aabb_hit_collector.md
# ray_aabb_hit_collector

Downstream companion of `Ray_AABB_11_12`. It carries a tag for every ray/box test issued to the core through a delay line matched to the core's fixed latency, pairs each tag with `hit_miss`, and builds one result record per ray: hit flag, first hit box, hit count. Records are queued in a small FIFO with a valid/ready output. The core itself cannot stall, so FIFO overflow is flagged rather than back-pressured.

## Interface
- `LATENCY`, 42, cycles from the edge on which operands are presented to `Ray_AABB_11_12` to the edge on which its `hit_miss` is valid for them; minimum 1.
- `ID_W`, 16, ray identifier width.
- `BOX_W`, 8, box index width.
- `FIFO_DEPTH`, 8, result records buffered; power of two, minimum 2.

- `clk` in 1: single clock, rising edge; shared with `Ray_AABB_11_12`.
- `rst` in 1: asynchronous, active-high reset.
- `issue_valid` in 1: operands presented to the core this cycle.
- `issue_ray_id` in `ID_W`: ray of this test.
- `issue_box_id` in `BOX_W`: box of this test.
- `issue_last` in 1: last box tested for this ray.
- `hit_miss` in 1: core result.
- `res_valid` out 1: record available.
- `res_ready` in 1: consumer accepts record.
- `res_ray_id` out `ID_W`: ray of the record.
- `res_hit` out 1: at least one box hit.
- `res_first_box` out `BOX_W`: lowest-order box hit in issue order; all ones if no hit.
- `res_hit_count` out `BOX_W+1`: number of hits; saturates at all ones.
- `overflow` out 1: sticky; a record was dropped because the FIFO was full.
- `seq_err` out 1: sticky; a ray id changed inside an open group.
- `busy` out 1: any tag is in flight, or a group is open.

## Operation
- **Delay line:** `LATENCY` register stages of {valid, ray_id, box_id, last}. Only the valid bit is reset; payload bits are not.
- **Result stage:** active when the delayed valid is 1; `hit_miss` is ignored otherwise.
- **Accumulator states:** IDLE (no open group) and OPEN.
- **IDLE + tag:**
  - Latch ray_id.
  - If `hit_miss` is 1: hit=1, first_box=box_id, count=1. Otherwise: hit=0, first_box=all ones, count=0.
  - If last=1, build the record immediately and stay in IDLE. Otherwise go to OPEN.
- **OPEN + tag:**
  - If ray_id differs from the latched id: set `seq_err`, close the current group as if it were last (push it), then handle this tag as IDLE + tag.
  - Otherwise, on a hit: if hit=0, set first_box=box_id; set hit=1; count+1, saturating.
  - If last=1: push the record and go to IDLE.
- **Push:**
  - If the FIFO is not full, or is full with a pop in the same cycle, the record is written.
  - Otherwise the record is discarded and `overflow` is set. Accumulator state still advances.
- **Pop:** on `res_valid && res_ready`. Output fields are driven directly from the FIFO head entry.
- **Sticky flags:** `overflow` and `seq_err` are cleared only by `rst`.
- **Reset mid-operation:**
  - Clears all delay-line valids, the accumulator (to IDLE), and the FIFO pointers.
  - In-flight tests are lost. The core's pipeline is not reset, but its stale `hit_miss` values are never consumed.

## Timing
- A test issued at edge t is evaluated at edge t+`LATENCY`, together with `hit_miss` sampled on that edge.
- A record pushed at edge e gives `res_valid`=1 after edge e; so a single-box ray issued at edge t shows `res_valid` after edge t+`LATENCY`.
- Throughput: one test per cycle sustained, with no issue-side stall.
- Reset values: `res_valid`=0, `overflow`=0, `seq_err`=0, `busy`=0. `res_ray_id`, `res_hit`, `res_first_box` and `res_hit_count` read 0, because the FIFO storage is reset to 0.
- `busy` is combinational from the OR of the delay-line valids and state==OPEN.
- FIFO count ranges 0..`FIFO_DEPTH`. Pointers wrap modulo `FIFO_DEPTH`, with an extra bit to tell full from empty.

## Test plan
- **Single ray:** ray 5, boxes 0..3 issued back-to-back, last on box 3; `hit_miss` 0,1,0,1 at edges t+42..t+45. Required record after edge t+45: ray 5, hit=1, first_box=1, count=2; `busy` falls after edge t+45.
- **Miss ray:** ray 9, boxes 0..2, all misses. Required record: hit=0, first_box=0xFF, count=0.
- **Overflow:** `res_ready`=0 while 9 single-box rays (ids 0..8) are issued. Required: the FIFO holds ids 0..7, `overflow`=1, id 8 is lost. Then raising `res_ready` drains 0..7 in order, one per cycle.
- **Full with simultaneous push/pop:** FIFO full, `res_ready`=1 on the push edge. Required: no drop, `overflow` stays 0, count stays at 8.
- **Ray id change inside a group:** ray 3 box 0 (last=0), then ray 4 box 0 (last=1). Required: `seq_err`=1; two records are produced (ray 3, then ray 4).
- **Reset mid-operation:** `rst` asserted 20 cycles after issuing a 4-box ray. Required: `busy` drops immediately (asynchronously), no record appears within the following 60 cycles, and outputs are at their reset values.
